dr_alm_mac_acc: RTL and testbench
=================================

# dr_alm_mac_acc

Streaming accumulator directly downstream of the DR-ALM multiplier core. It consumes signed approximate products over a valid/ready handshake and sums a programmable number of them into a wide accumulator. It then presents the dot-product result with a hold-until-accepted output handshake. This turns the combinational log multiplier into a dot-product / MAC engine for the error-analysis and filter benches.

## Interface
- WIDTH, 16: multiplier operand width; products are 2*WIDTH bits signed.
- ACC_WIDTH, 40: accumulator width, signed; must be >= 2*WIDTH (elaboration error otherwise).
- LEN_WIDTH, 8: width of the vector-length input.
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clear  in  1  synchronous abort/clear, highest priority after reset.
- i_len  in  LEN_WIDTH  products per result, unsigned; sampled on first accepted beat of a vector.
- i_valid  in  1  product beat valid.
- o_ready  out  1  accumulator can accept a beat (registered).
- i_prod  in  2*WIDTH  signed product (multiplier o_z).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_acc  out  ACC_WIDTH  signed accumulated result.
- o_ovf  out  1  overflow occurred in this vector (sticky per vector).

## Operation
- Beat accepted when i_valid && o_ready at a rising edge. Result accepted when o_valid && i_ready.
- States: IDLE, ACC, HOLD.
- IDLE: o_ready=1, o_valid=0. On an accepted beat:
  - latch len = (i_len==0 ? 1 : i_len);
  - acc = sext(i_prod); count = 1.
  - If len==1, go to HOLD; else go to ACC.
- ACC: o_ready=1. Each accepted beat does acc = acc + sext(i_prod) and count = count+1. When count reaches len, go to HOLD. Cycles with i_valid=0 leave everything unchanged.
- HOLD: o_ready=0, o_valid=1. o_acc and o_ovf stay stable until accepted. On accept, go to IDLE, acc cleared, o_ovf cleared.
- Arithmetic: i_prod is sign-extended to ACC_WIDTH, and the sum is computed at ACC_WIDTH+1 bits. Overflow means the two MSBs of the sum differ. Handling depends on the configuration macro.
- i_clear=1 at an edge, in any state:
  - state goes to IDLE; acc, count, o_ovf, o_valid = 0;
  - a beat presented in that cycle is dropped.
- Counter width is LEN_WIDTH+1, so len = 2^LEN_WIDTH-1 completes without wrap.

## Timing
- Reset values: o_valid=0, o_ready=0, o_acc=0, o_ovf=0, state=IDLE. o_ready rises on the first clock edge after i_rst_n deasserts.
- Reset asserted mid-vector or in HOLD: all state is cleared immediately (asynchronous). A pending result is lost.
- Latency: o_valid asserts on the edge that accepts the len-th beat, i.e. it is visible 1 cycle after that beat. A vector with no stalls takes len cycles in plus ≥1 cycle in HOLD.
- o_ready goes 0 in the same edge that enters HOLD; no beat is accepted in HOLD. It returns to 1 on the edge that leaves HOLD, which means 1 bubble cycle per vector.
- i_ready may be held high continuously; in that case HOLD lasts exactly 1 cycle.
- i_len changes mid-vector are ignored until the next vector.

## Configuration
- ACC_SATURATE_EN defined:
  - on overflow, acc clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1), according to the sum's true sign;
  - o_ovf is set and stays set until the result is accepted or cleared;
  - later beats continue from the clamped value.
- ACC_SATURATE_EN undefined: two's-complement wrap at ACC_WIDTH bits; o_ovf tied to 0.

## Test plan
- Basic: WIDTH=16, ACC_WIDTH=40, i_len=4, products 100, -50, 25, 1 on consecutive cycles, i_ready=1 -> o_acc=76, o_valid high exactly 1 cycle, one cycle after the 4th beat; o_ovf=0.
- Backpressure and stalls: i_len=3, products 7, 8, 9 with i_valid gaps of 2 cycles, then i_ready=0 for 3 cycles -> o_acc=24 held stable, o_ready=0 throughout HOLD, accepted on the cycle i_ready rises.
- Overflow with ACC_WIDTH=32, i_len=3, three products of 1073676289 (32767²):
  - with ACC_SATURATE_EN -> o_acc=2147483647, o_ovf=1;
  - without -> o_acc=-1073938429, o_ovf=0.
- Length edge cases: i_len=0 with product -5 -> result -5 after 1 beat. Then i_len=255 with all products 1 -> o_acc=255, and the next vector starts clean with o_acc=0 base.
- i_clear in ACC after 2 of 4 beats -> state IDLE, o_valid stays 0. Next vector of i_len=1, product 3 -> o_acc=3.
- Async reset mid-vector and again in HOLD -> all outputs 0 immediately; o_ready=1 one edge after release; a following vector computes correctly.

Source files
------------

// File: rtl/dr_alm_mac_acc.sv
// dr_alm_mac_acc: streaming signed accumulator behind the DR-ALM multiplier.
// Sums a programmable number of 2*WIDTH-bit signed products into an ACC_WIDTH
// accumulator, then holds the result until the consumer accepts it.
// Optional feature macro: ACC_SATURATE_EN (saturating accumulate plus sticky
// per-vector overflow flag). When it is undefined, the accumulator wraps and
// o_ovf is held at 0.
module dr_alm_mac_acc #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clear,
  input  logic [LEN_WIDTH-1:0]        i_len,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [2*WIDTH-1:0]   i_prod,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [ACC_WIDTH-1:0] o_acc,
  output logic                        o_ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  // One extra bit so that len = 2^LEN_WIDTH-1 completes without wrapping.
  localparam int unsigned CW = LEN_WIDTH + 1;

  // Reject an accumulator narrower than a single product.
  if (ACC_WIDTH < PW) begin : g_cfg_err
    $error("dr_alm_mac_acc: ACC_WIDTH must be >= 2*WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                      state_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [CW-1:0]               count_q;
  logic [CW-1:0]               len_q;
  logic                        ovf_q;
  logic                        valid_q;
  logic                        ready_q;

  logic signed [ACC_WIDTH-1:0] prod_ext_c;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic                        ovf_hit_c;
  logic [CW-1:0]               len_eff_c;
  logic [CW-1:0]               count_inc_c;

  // Sign-extend the incoming product to accumulator width.
  assign prod_ext_c = ACC_WIDTH'(i_prod);

`ifdef ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum_c;

  // Sum one bit wider than the accumulator; differing top bits flag overflow
  // and the top bit carries the true sign used to pick the clamp rail.
  assign sum_c     = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_ext_c);
  assign ovf_hit_c = sum_c[ACC_WIDTH] ^ sum_c[ACC_WIDTH-1];
  assign acc_d     = !ovf_hit_c ? sum_c[ACC_WIDTH-1:0]
                                : (sum_c[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
`else
  // Plain two's-complement wrap at accumulator width.
  assign acc_d     = acc_q + prod_ext_c;
  assign ovf_hit_c = 1'b0;
`endif

  // A zero length is treated as a single-product vector.
  assign len_eff_c   = (i_len == '0) ? CW'(1) : CW'(i_len);
  assign count_inc_c = count_q + CW'(1);

  // Vector FSM: accumulate beats, then hold the result until accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else if (i_clear) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          if (i_valid && ready_q) begin
            len_q   <= len_eff_c;
            acc_q   <= prod_ext_c;
            count_q <= CW'(1);
            ovf_q   <= 1'b0;
            if (len_eff_c == CW'(1)) begin
              state_q <= ST_HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (i_valid) begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_q | ovf_hit_c;
            count_q <= count_inc_c;
            if (count_inc_c == len_q) begin
              state_q <= ST_HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          acc_q   <= '0;
          count_q <= '0;
          ovf_q   <= 1'b0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_acc   = acc_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_dr_alm_mac_acc.sv
// Bench for dr_alm_mac_acc: a 40-bit and a 32-bit accumulator instance share
// one stimulus stream; expected sums come from a queue-based arithmetic model.
// Honours ACC_SATURATE_EN the same way the design does.
module tb_dr_alm_mac_acc;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic [7:0]         len;
  logic               valid;
  logic signed [31:0] prod;
  logic               rdy;

  logic               ready40, valid40, ovf40;
  logic signed [39:0] acc40;
  logic               ready32, valid32, ovf32;
  logic signed [31:0] acc32;

  int vectors;
  int miscompares;

  typedef struct {
    logic signed [39:0] acc40;
    logic signed [31:0] acc32;
    logic               ovf40;
    logic               ovf32;
    logic               valid_done;
    int                 early_valid;
    int                 not_ready;
    int                 hold_bad;
    logic               valid_after;
    logic               ready_after;
    logic signed [39:0] acc_after;
  } obs_t;

  dr_alm_mac_acc #(.WIDTH(16), .ACC_WIDTH(40), .LEN_WIDTH(8)) u_dut40 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_len(len),
    .i_valid(valid), .o_ready(ready40), .i_prod(prod), .o_valid(valid40),
    .i_ready(rdy), .o_acc(acc40), .o_ovf(ovf40)
  );

  dr_alm_mac_acc #(.WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(8)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_len(len),
    .i_valid(valid), .o_ready(ready32), .i_prod(prod), .o_valid(valid32),
    .i_ready(rdy), .o_acc(acc32), .o_ovf(ovf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: running sum of the vector's products at the given width.
  function automatic longint model_sum(input logic signed [31:0] q[$], input int accw,
                                       output bit ovf);
    longint s;
`ifdef ACC_SATURATE_EN
    longint mn;
    longint mx;
    mn = -(longint'(1) <<< (accw - 1));
    mx = -mn - 1;
`endif
    s   = 0;
    ovf = 1'b0;
    foreach (q[k]) begin
      s = s + longint'(q[k]);
`ifdef ACC_SATURATE_EN
      if (s > mx) begin s = mx; ovf = 1'b1; end
      else if (s < mn) begin s = mn; ovf = 1'b1; end
`else
      s = (s <<< (64 - accw)) >>> (64 - accw);
`endif
    end
    return s;
  endfunction

  // Drive one vector (with idle gaps and result backpressure) and record what was seen.
  task automatic run_vector(input logic [7:0] l, input logic signed [31:0] q[$],
                            input int gap, input int hold, output obs_t o);
    o = '{default: '0};
    rdy = (hold == 0);
    foreach (q[k]) begin
      repeat (gap) begin
        valid = 1'b0;
        @(posedge clk); #1;
        if (valid40 || valid32) o.early_valid++;
      end
      len   = (k == 0) ? l : 8'($urandom);
      valid = 1'b1;
      prod  = q[k];
      if (!(ready40 && ready32)) o.not_ready++;
      @(posedge clk); #1;
      valid = 1'b0;
      if ((k < q.size() - 1) && (valid40 || valid32)) o.early_valid++;
    end
    o.valid_done = valid40 & valid32;
    o.acc40      = acc40;
    o.acc32      = acc32;
    o.ovf40      = ovf40;
    o.ovf32      = ovf32;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!valid40 || !valid32 || ready40 || ready32 || acc40 !== o.acc40 ||
          acc32 !== o.acc32 || ovf32 !== o.ovf32) o.hold_bad++;
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    o.valid_after = valid40 | valid32;
    o.ready_after = ready40 & ready32;
    o.acc_after   = acc40;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (ready40 !== 1'b0 || valid40 !== 1'b0 || acc40 !== 40'sd0 || ovf40 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b acc=%0d ovf=%b want 0 0 0 0",
               ready40, valid40, acc40, ovf40);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ready40 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_early: got %b want 0", ready40);
    end
    @(posedge clk); #1;
    vectors++;
    if (ready40 !== 1'b1 || ready32 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_rise: got %b/%b want 1/1", ready40, ready32);
    end
  endtask

  task automatic test_basic();
    logic signed [31:0] q[$];
    obs_t o;
    q = {};
    q.push_back(32'sd100); q.push_back(-32'sd50); q.push_back(32'sd25); q.push_back(32'sd1);
    run_vector(8'd4, q, 0, 0, o);
    vectors++;
    if (o.valid_done !== 1'b1 || o.early_valid != 0 || o.not_ready != 0) begin
      miscompares++;
      $display("FAIL basic_timing: got done=%b early=%0d notrdy=%0d want 1 0 0",
               o.valid_done, o.early_valid, o.not_ready);
    end
    vectors++;
    if (o.acc40 !== 40'sd76 || o.acc32 !== 32'sd76 || o.ovf40 !== 1'b0 || o.ovf32 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_acc: got %0d/%0d ovf %b/%b want 76/76 ovf 0/0",
               o.acc40, o.acc32, o.ovf40, o.ovf32);
    end
    vectors++;
    if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1 || o.acc_after !== 40'sd0) begin
      miscompares++;
      $display("FAIL basic_accept: got vld=%b rdy=%b acc=%0d want 0 1 0",
               o.valid_after, o.ready_after, o.acc_after);
    end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] q[$];
    obs_t o;
    q = {};
    q.push_back(32'sd7); q.push_back(32'sd8); q.push_back(32'sd9);
    run_vector(8'd3, q, 2, 3, o);
    vectors++;
    if (o.acc40 !== 40'sd24 || o.acc32 !== 32'sd24 || o.valid_done !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_acc: got %0d/%0d done=%b want 24/24 done=1", o.acc40, o.acc32, o.valid_done);
    end
    vectors++;
    if (o.hold_bad != 0 || o.early_valid != 0) begin
      miscompares++;
      $display("FAIL bp_hold_stable: got bad=%0d early=%0d want 0 0", o.hold_bad, o.early_valid);
    end
    vectors++;
    if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept: got vld=%b rdy=%b want 0 1", o.valid_after, o.ready_after);
    end
  endtask

  task automatic test_overflow();
    logic signed [31:0] q[$];
    obs_t o;
    logic signed [31:0] e32;
    logic e_ovf;
`ifdef ACC_SATURATE_EN
    e32 = 32'sd2147483647; e_ovf = 1'b1;
`else
    e32 = -32'sd1073938429; e_ovf = 1'b0;
`endif
    q = {};
    repeat (3) q.push_back(32'sd1073676289);
    run_vector(8'd3, q, 0, 1, o);
    vectors++;
    if (o.acc32 !== e32 || o.ovf32 !== e_ovf) begin
      miscompares++;
      $display("FAIL ovf_acc32: got %0d ovf=%b want %0d ovf=%b", o.acc32, o.ovf32, e32, e_ovf);
    end
    vectors++;
    if (o.acc40 !== 40'sd3221028867 || o.ovf40 !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_acc40: got %0d ovf=%b want 3221028867 ovf=0", o.acc40, o.ovf40);
    end
    vectors++;
    if (o.hold_bad != 0 || o.valid_after !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_hold: got bad=%0d vld_after=%b want 0 0", o.hold_bad, o.valid_after);
    end
  endtask

  task automatic test_len_edges();
    logic signed [31:0] q[$];
    obs_t o;
    q = {};
    q.push_back(-32'sd5);
    run_vector(8'd0, q, 0, 0, o);
    vectors++;
    if (o.acc40 !== -40'sd5 || o.acc32 !== -32'sd5 || o.valid_done !== 1'b1) begin
      miscompares++;
      $display("FAIL len0: got %0d/%0d done=%b want -5/-5 done=1", o.acc40, o.acc32, o.valid_done);
    end
    q = {};
    repeat (255) q.push_back(32'sd1);
    run_vector(8'd255, q, 0, 0, o);
    vectors++;
    if (o.acc40 !== 40'sd255 || o.acc32 !== 32'sd255 || o.valid_done !== 1'b1 || o.early_valid != 0) begin
      miscompares++;
      $display("FAIL len255: got %0d/%0d done=%b early=%0d want 255/255 1 0",
               o.acc40, o.acc32, o.valid_done, o.early_valid);
    end
    q = {};
    q.push_back(32'sd3); q.push_back(32'sd4);
    run_vector(8'd2, q, 0, 0, o);
    vectors++;
    if (o.acc40 !== 40'sd7 || o.acc32 !== 32'sd7) begin
      miscompares++;
      $display("FAIL len_after255: got %0d/%0d want 7/7", o.acc40, o.acc32);
    end
  endtask

  task automatic test_clear();
    logic signed [31:0] q[$];
    obs_t o;
    len = 8'd4;
    repeat (2) begin
      valid = 1'b1; prod = 32'sd50;
      @(posedge clk); #1;
    end
    clear = 1'b1; valid = 1'b1; prod = 32'sd1000;
    @(posedge clk); #1;
    clear = 1'b0; valid = 1'b0;
    vectors++;
    if (valid40 !== 1'b0 || ready40 !== 1'b1 || acc40 !== 40'sd0 || ovf32 !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_state: got vld=%b rdy=%b acc=%0d ovf=%b want 0 1 0 0",
               valid40, ready40, acc40, ovf32);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (valid40 !== 1'b0 || valid32 !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_no_valid: got %b/%b want 0/0", valid40, valid32);
    end
    q = {};
    q.push_back(32'sd3);
    run_vector(8'd1, q, 0, 0, o);
    vectors++;
    if (o.acc40 !== 40'sd3 || o.acc32 !== 32'sd3 || o.valid_done !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_next: got %0d/%0d done=%b want 3/3 1", o.acc40, o.acc32, o.valid_done);
    end
  endtask

  task automatic test_async_reset();
    logic signed [31:0] q[$];
    obs_t o;
    // Mid-vector reset.
    len = 8'd5;
    repeat (2) begin
      valid = 1'b1; prod = 32'sd11;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ready40 !== 1'b0 || valid40 !== 1'b0 || acc40 !== 40'sd0 || acc32 !== 32'sd0) begin
      miscompares++;
      $display("FAIL arst_mid: got rdy=%b vld=%b acc=%0d/%0d want 0 0 0/0",
               ready40, valid40, acc40, acc32);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ready40 !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_mid_release: got rdy=%b want 1", ready40);
    end
    // Reset while holding a result.
    rdy = 1'b0; len = 8'd1; valid = 1'b1; prod = 32'sd9;
    @(posedge clk); #1;
    valid = 1'b0;
    vectors++;
    if (valid40 !== 1'b1 || acc40 !== 40'sd9) begin
      miscompares++;
      $display("FAIL arst_hold_pre: got vld=%b acc=%0d want 1 9", valid40, acc40);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (valid40 !== 1'b0 || acc40 !== 40'sd0 || ready40 !== 1'b0 || valid32 !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_hold: got vld=%b acc=%0d rdy=%b want 0 0 0", valid40, acc40, ready40);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b1;
    q = {};
    q.push_back(-32'sd3); q.push_back(32'sd10);
    run_vector(8'd2, q, 0, 0, o);
    vectors++;
    if (o.acc40 !== 40'sd7 || o.acc32 !== 32'sd7 || o.valid_done !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_after: got %0d/%0d done=%b want 7/7 1", o.acc40, o.acc32, o.valid_done);
    end
  endtask

  task automatic test_random();
    logic signed [31:0] q[$];
    obs_t o;
    longint e40, e32;
    bit eo40, eo32;
    int n;
    logic [7:0] l;
    for (int v = 0; v < 25; v++) begin
      l = 8'($urandom_range(0, 8));
      n = (l == 8'd0) ? 1 : int'(l);
      q = {};
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 0) q.push_back(32'($urandom));
        else q.push_back(32'($signed(16'($urandom))));
      end
      e40 = model_sum(q, 40, eo40);
      e32 = model_sum(q, 32, eo32);
      run_vector(l, q, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), o);
      vectors++;
      if (o.acc40 !== 40'(e40) || o.ovf40 !== eo40) begin
        miscompares++;
        $display("FAIL rand40[%0d]: got %0d ovf=%b want %0d ovf=%b", v, o.acc40, o.ovf40, e40, eo40);
      end
      vectors++;
      if (o.acc32 !== 32'(e32) || o.ovf32 !== eo32) begin
        miscompares++;
        $display("FAIL rand32[%0d]: got %0d ovf=%b want %0d ovf=%b", v, o.acc32, o.ovf32, e32, eo32);
      end
      vectors++;
      if (o.valid_done !== 1'b1 || o.early_valid != 0 || o.not_ready != 0 ||
          o.hold_bad != 0 || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_proto[%0d]: got done=%b early=%0d notrdy=%0d hold=%0d vld=%b rdy=%b want 1 0 0 0 0 1",
                 v, o.valid_done, o.early_valid, o.not_ready, o.hold_bad, o.valid_after, o.ready_after);
      end
    end
  endtask

  // Hard stop if the run ever wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; clear = 1'b0; len = 8'd0; valid = 1'b0; prod = 32'sd0; rdy = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_len_edges();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
